// File: rtl/pwm_capture.sv
// PWM measurement receiver: consumes NS samples per clock and reports each
// complete cycle's period and high time in sample units.
module pwm_capture #(
  parameter int WIDTH  = 18,
  parameter int HRBITS = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [(1<<HRBITS)-1:0]   pwmD,
  output logic [WIDTH:0]           period,
  output logic [WIDTH:0]           high,
  output logic                     meas_valid,
  output logic                     glitch,
  output logic                     timeout
);

  localparam int NS = 1 << HRBITS;
  localparam int RW = WIDTH + 1;

  function automatic logic [HRBITS:0] popcnt(input logic [NS-1:0] v);
    logic [HRBITS:0] c;
    c = '0;
    for (int i = 0; i < NS; i++) c = c + {{HRBITS{1'b0}}, v[i]};
    return c;
  endfunction

  function automatic logic [RW-1:0] sat_add(input logic [RW-1:0] a, input logic [RW-1:0] b);
    logic [RW:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[RW] ? {RW{1'b1}} : s[RW-1:0];
  endfunction

  logic          prev_q, prev_d;
  logic [RW-1:0] acc_p_q, acc_p_d, acc_h_q, acc_h_d;
  logic          armed_q, armed_d;
  logic          sat_q, sat_d;
  logic [RW-1:0] period_q, period_d, high_q, high_d;
  logic          valid_q, valid_d, glitch_q, glitch_d, timeout_q, timeout_d;

  logic [NS-1:0]     prev_vec, rise, below_mask;
  logic [HRBITS-1:0] pos;
  logic              multi;
  logic [HRBITS:0]   pop_all, pop_lo, pop_hi;
  logic [RW:0]       step_p;

  // pos ends up at the last (highest) rising edge; for a single edge it is k.
  always_comb begin
    prev_vec   = {pwmD[NS-2:0], prev_q};
    rise       = pwmD & ~prev_vec;
    pos        = '0;
    for (int i = 0; i < NS; i++) if (rise[i]) pos = HRBITS'(i);
    multi      = |(rise & (rise - NS'(1)));
    below_mask = (NS'(1) << pos) - NS'(1);
    pop_all    = popcnt(pwmD);
    pop_lo     = popcnt(pwmD & below_mask);
    pop_hi     = pop_all - pop_lo;
    step_p     = {1'b0, acc_p_q} + (RW+1)'(NS);
  end

  always_comb begin
    // NOTE: every next-state signal gets a default first so no latch is inferred.
    prev_d    = pwmD[NS-1];
    acc_p_d   = acc_p_q;
    acc_h_d   = acc_h_q;
    armed_d   = armed_q;
    sat_d     = sat_q;
    period_d  = period_q;
    high_d    = high_q;
    valid_d   = 1'b0;
    glitch_d  = 1'b0;
    timeout_d = 1'b0;

    if (rise == '0) begin
      acc_h_d = sat_add(acc_h_q, RW'(pop_all));
      // Once clamped, acc_p holds at all-ones and timeout stays quiet until an edge.
      if (!sat_q) begin
        if (step_p[RW]) begin
          acc_p_d   = {RW{1'b1}};
          sat_d     = 1'b1;
          armed_d   = 1'b0;
          timeout_d = 1'b1;
        end else begin
          acc_p_d = step_p[RW-1:0];
        end
      end
    end else begin
      if (multi) begin
        glitch_d = 1'b1;
      end else if (armed_q) begin
        period_d = sat_add(acc_p_q, RW'(pos));
        high_d   = sat_add(acc_h_q, RW'(pop_lo));
        valid_d  = 1'b1;
      end
      acc_p_d = RW'(NS) - RW'(pos);
      acc_h_d = RW'(pop_hi);
      armed_d = 1'b1;
      sat_d   = 1'b0;
    end
  end

  // NOTE: reset is synchronous, so it lives inside the clocked block's if.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q    <= 1'b0;
      acc_p_q   <= '0;
      acc_h_q   <= '0;
      armed_q   <= 1'b0;
      sat_q     <= 1'b0;
      period_q  <= '0;
      high_q    <= '0;
      valid_q   <= 1'b0;
      glitch_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      prev_q    <= prev_d;
      acc_p_q   <= acc_p_d;
      acc_h_q   <= acc_h_d;
      armed_q   <= armed_d;
      sat_q     <= sat_d;
      period_q  <= period_d;
      high_q    <= high_d;
      valid_q   <= valid_d;
      glitch_q  <= glitch_d;
      timeout_q <= timeout_d;
    end
  end

  assign period     = period_q;
  assign high       = high_q;
  assign meas_valid = valid_q;
  assign glitch     = glitch_q;
  assign timeout    = timeout_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture (NS=8, WIDTH=18); a second instance runs the
// full 2^18-sample period concurrently with the main instance's timeout run.
module tb_pwm_capture;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  pwm_m = '0;
  logic [7:0]  pwm_l = '0;
  logic [18:0] period_m, high_m, period_l, high_l;
  logic        valid_m, glitch_m, timeout_m;
  logic        valid_l, glitch_l, timeout_l;

  int checks   = 0;
  int failures = 0;
  int to_cnt_m = 0;
  int to_cnt_l = 0;

  always #5 clk = ~clk;

  pwm_capture dut (
    .clk(clk), .rst(rst), .pwmD(pwm_m),
    .period(period_m), .high(high_m),
    .meas_valid(valid_m), .glitch(glitch_m), .timeout(timeout_m)
  );

  pwm_capture dut_long (
    .clk(clk), .rst(rst), .pwmD(pwm_l),
    .period(period_l), .high(high_l),
    .meas_valid(valid_l), .glitch(glitch_l), .timeout(timeout_l)
  );

  always @(negedge clk) begin
    if (timeout_m) to_cnt_m++;
    if (timeout_l) to_cnt_l++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one word on each instance; outputs are sampled 1ns after the edge.
  task automatic step(input logic [7:0] wm, input logic [7:0] wl);
    pwm_m = wm;
    pwm_l = wl;
    @(posedge clk);
    #1;
  endtask

  // Ideal generator: sample t is 1 when (t-off) mod p < h.
  function automatic logic [7:0] gen(input int t0, input int p, input int h, input int off);
    logic [7:0] w;
    int r;
    for (int i = 0; i < 8; i++) begin
      r    = (((t0 + i - off) % p) + p) % p;
      w[i] = (r < h);
    end
    return w;
  endfunction

  function automatic logic [7:0] long_word(input int i);
    if (i == 0)          return 8'h00;
    else if (i <= 23265) return 8'hFF;
    else if (i == 23266) return 8'h01;
    else if (i == 32769) return 8'hFF;
    else                 return 8'h00;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    step(8'h00, 8'h00);
    rst = 1'b0;
  endtask

  initial begin
    int base_m, base_l;

    // Reset state
    rst = 1'b1;
    step(8'hFF, 8'h00);
    step(8'hFF, 8'h00);
    check("rst_period", period_m, 0);
    check("rst_high", high_m, 0);
    check("rst_flags", {valid_m, glitch_m, timeout_m}, 3'b000);
    rst = 1'b0;

    // Loopback: period 80, high 30, edge at k=3
    for (int w = 0; w < 40; w++) begin
      step(gen(w * 8, 80, 30, 3), 8'h00);
      check("lb_glitch", glitch_m, 0);
      if (w > 0 && w % 10 == 0) begin
        check("lb_valid", valid_m, 1);
        check("lb_period", period_m, 80);
        check("lb_high", high_m, 30);
      end else begin
        check("lb_novalid", valid_m, 0);
      end
    end

    // Edge across word boundary: k=0, period 16, high 8
    do_reset();
    step(8'h00, 8'h00);
    step(8'hFF, 8'h00);
    check("xb_arm_only", valid_m, 0);
    step(8'h00, 8'h00);
    step(8'hFF, 8'h00);
    check("xb_valid", valid_m, 1);
    check("xb_period", period_m, 16);
    check("xb_high", high_m, 8);
    step(8'h00, 8'h00);
    step(8'hFF, 8'h00);
    check("xb_valid2", valid_m, 1);
    check("xb_period2", period_m, 16);
    check("xb_high2", high_m, 8);

    // Glitch: restart at m=6 with acc_p=2, acc_h=1, armed
    do_reset();
    step(8'h00, 8'h00);
    step(8'h55, 8'h00);
    check("gl_flags", {valid_m, glitch_m, timeout_m}, 3'b010);
    check("gl_period_held", period_m, 0);
    step(8'h00, 8'h00);
    check("gl_pulse_once", glitch_m, 0);
    step(8'h01, 8'h00);
    check("gl_next_valid", valid_m, 1);
    check("gl_next_period", period_m, 10);
    check("gl_next_high", high_m, 1);

    // Reset mid-period of a 1000-sample waveform (high 400, edge at t=2)
    do_reset();
    for (int w = 0; w < 60; w++) step(gen(w * 8, 1000, 400, 2), 8'h00);
    rst = 1'b1;
    step(gen(480, 1000, 400, 2), 8'h00);
    rst = 1'b0;
    check("mr_period", period_m, 0);
    check("mr_high", high_m, 0);
    check("mr_flags", {valid_m, glitch_m, timeout_m}, 3'b000);
    for (int w = 61; w <= 250; w++) begin
      step(gen(w * 8, 1000, 400, 2), 8'h00);
      if (w == 250) begin
        check("mr_valid", valid_m, 1);
        check("mr_period1000", period_m, 1000);
        check("mr_high400", high_m, 400);
      end else begin
        check("mr_novalid", valid_m, 0);
      end
    end

    // Timeout on main (2^19 zero samples) alongside the 2^18 full period on dut_long
    do_reset();
    base_m = to_cnt_m;
    base_l = to_cnt_l;
    for (int i = 0; i < 65536; i++) begin
      step(8'h00, long_word(i));
      if (i == 65534) check("to_not_early", timeout_m, 0);
      if (i == 65535) check("to_pulse", timeout_m, 1);
      if (i == 1) check("long_arm_only", valid_l, 0);
      if (i == 32769) begin
        check("long_valid", valid_l, 1);
        check("long_period", period_l, 32'h40000);
        check("long_high", high_l, 32'h2D709);
      end
    end
    for (int i = 0; i < 3; i++) step(8'h00, 8'h00);
    check("to_count_once", to_cnt_m - base_m, 1);
    check("long_no_timeout", to_cnt_l - base_l, 0);
    check("long_no_glitch", glitch_l, 0);
    step(8'h0F, 8'h00);
    check("to_rearm_only", valid_m, 0);
    for (int i = 0; i < 3; i++) step(8'h00, 8'h00);
    step(8'h0F, 8'h00);
    check("to_after_valid", valid_m, 1);
    check("to_after_period", period_m, 32);
    check("to_after_high", high_m, 4);
    check("to_count_final", to_cnt_m - base_m, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
